apb_slave_mem: RTL and testbench

APB completer that terminates the 4-bit-address / 8-bit-data APB bus driven by the team's APB requester. It owns a small register file of `MEM_DEPTH` bytes and answers every transfer with a parameterisable number of wait states. Out-of-range transfers complete with `pslverr`. It sits on the peripheral side of the APB link, one instance per select line.

---
 rtl/apb_slave_mem.sv | 101 ++++++++++
 tb/tb_apb_slave_mem.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer: 4-bit address / 8-bit data register file of MEM_DEPTH bytes,
// WAIT_CYCLES wait states per transfer and pslverr on out-of-range addresses.
module apb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(MEM_DEPTH);
    endfunction

    // Out-of-range reads return zero rather than touching the array.
    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        return in_range(a) ? mem[a] : '0;
    endfunction

    // presetn is active-high here; reset outranks any completion on the same edge.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            wr      <= 1'b0;
            wdata   <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            mem     <= '{default: '0};
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        addr  <= paddr;
                        wr    <= pwrite;
                        wdata <= pwdata;
                        cnt   <= CW'(WAIT_CYCLES);
                        state <= ACCESS;
                        // Zero wait states: response must already be up in A1.
                        if (WAIT_CYCLES == 0) begin
                            pready  <= 1'b1;
                            pslverr <= !in_range(paddr);
                            prdata  <= rd_mem(paddr);
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                    end else if (penable) begin
                        if (pready) begin
                            if (wr && in_range(addr)) begin
                                mem[addr] <= wdata;
                            end
                            state   <= IDLE;
                            pready  <= 1'b0;
                            pslverr <= 1'b0;
                            prdata  <= '0;
                        end else if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                            if (cnt == CW'(1)) begin
                                pready  <= 1'b1;
                                pslverr <= !in_range(addr);
                                prdata  <= rd_mem(addr);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 2 and 3 wait states.
module tb_apb_slave_mem;

    logic       pclk = 1'b0;
    logic       presetn;
    logic [2:0] psel_v;
    logic       penable;
    logic       pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata_v  [3];
    logic       pready_v  [3];
    logic       pslverr_v [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] model [16];

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_mem #(.MEM_DEPTH(12), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_slave_mem #(.MEM_DEPTH(12), .WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_slave_mem #(.MEM_DEPTH(12), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transfer on instance d; called just after a rising edge.
    task automatic apb_xfer(input logic [1:0] d, input logic w, input logic [3:0] a,
                            input logic [7:0] wd, output logic [7:0] rd,
                            output logic err, output int waits, output int done_cyc);
        psel_v    = '0;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = w;
        paddr     = a;
        pwdata    = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        while (!pready_v[d] && waits < 20) begin
            waits++;
            @(posedge pclk); #1;
        end
        check("pready_seen", 32'(pready_v[d]), 32'd1);
        rd  = prdata_v[d];
        err = pslverr_v[d];
        @(posedge pclk); #1;
        done_cyc = cyc;
        psel_v   = '0;
        penable  = 1'b0;
        check("pready_one_cycle", 32'(pready_v[d]), 32'd0);
        if (w && a < 4'd12) model[a] = wd;
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         waits, c1, c2, c3;

        presetn = 1'b1;
        psel_v  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        repeat (2) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_pready",  32'(pready_v[i]),  32'd0);
            check("reset_pslverr", 32'(pslverr_v[i]), 32'd0);
            check("reset_prdata",  32'(prdata_v[i]),  32'd0);
        end
        presetn = 1'b0;
        @(posedge pclk); #1;

        // Basic write/read, no wait states
        apb_xfer(2'd0, 1'b1, 4'd3, 8'hA5, rd, err, waits, c1);
        check("w0_wr_waits", 32'(waits), 32'd0);
        check("w0_wr_err",   32'(err),   32'd0);
        apb_xfer(2'd0, 1'b0, 4'd3, 8'h00, rd, err, waits, c1);
        check("w0_rd_waits", 32'(waits), 32'd0);
        check("w0_rd_data",  32'(rd),    32'hA5);
        check("w0_rd_err",   32'(err),   32'd0);

        // Two wait states: ready in A3, done 3 cycles after the setup edge
        c1 = cyc;
        apb_xfer(2'd1, 1'b0, 4'd0, 8'h00, rd, err, waits, c2);
        check("w2_waits",   32'(waits),       32'd2);
        check("w2_data",    32'(rd),          32'h00);
        check("w2_latency", 32'(c2 - c1 - 1), 32'd3);

        // Out of range on address 13
        apb_xfer(2'd0, 1'b1, 4'd13, 8'h55, rd, err, waits, c1);
        check("oor_wr_err", 32'(err), 32'd1);
        apb_xfer(2'd0, 1'b0, 4'd13, 8'h00, rd, err, waits, c1);
        check("oor_rd_err",  32'(err), 32'd1);
        check("oor_rd_data", 32'(rd),  32'h00);
        for (int i = 0; i < 12; i++) begin
            apb_xfer(2'd0, 1'b0, 4'(i), 8'h00, rd, err, waits, c1);
            check("oor_mem_intact", 32'(rd), 32'(model[i]));
        end

        // Back-to-back writes then readback
        apb_xfer(2'd0, 1'b1, 4'd1, 8'h11, rd, err, waits, c1);
        apb_xfer(2'd0, 1'b1, 4'd2, 8'h22, rd, err, waits, c2);
        apb_xfer(2'd0, 1'b1, 4'd3, 8'h33, rd, err, waits, c3);
        check("b2b_gap1", 32'(c2 - c1), 32'd2);
        check("b2b_gap2", 32'(c3 - c2), 32'd2);
        apb_xfer(2'd0, 1'b0, 4'd1, 8'h00, rd, err, waits, c1);
        check("b2b_rd1", 32'(rd), 32'h11);
        apb_xfer(2'd0, 1'b0, 4'd2, 8'h00, rd, err, waits, c1);
        check("b2b_rd2", 32'(rd), 32'h22);
        apb_xfer(2'd0, 1'b0, 4'd3, 8'h00, rd, err, waits, c1);
        check("b2b_rd3", 32'(rd), 32'h33);

        // Abort on the 3-wait instance after seeding addr 5
        apb_xfer(2'd2, 1'b1, 4'd5, 8'h5A, rd, err, waits, c1);
        check("w3_wr_waits", 32'(waits), 32'd3);
        psel_v  = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 4'd5;
        pwdata  = 8'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_a1_pready", 32'(pready_v[2]), 32'd0);
        @(posedge pclk); #1;
        check("abort_a2_pready", 32'(pready_v[2]), 32'd0);
        psel_v  = '0;
        penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_after_pready",  32'(pready_v[2]),  32'd0);
        check("abort_after_pslverr", 32'(pslverr_v[2]), 32'd0);
        apb_xfer(2'd2, 1'b0, 4'd5, 8'h00, rd, err, waits, c1);
        check("abort_rd5", 32'(rd), 32'h5A);

        // Reset during A1 of a write
        apb_xfer(2'd0, 1'b1, 4'd4, 8'h99, rd, err, waits, c1);
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 4'd6;
        pwdata  = 8'h44;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("rst_a1_pready", 32'(pready_v[0]), 32'd1);
        presetn = 1'b1;
        @(posedge pclk); #1;
        check("rst_pready",  32'(pready_v[0]),  32'd0);
        check("rst_pslverr", 32'(pslverr_v[0]), 32'd0);
        check("rst_prdata",  32'(prdata_v[0]),  32'd0);
        presetn = 1'b0;
        psel_v  = '0;
        penable = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(posedge pclk); #1;
        apb_xfer(2'd0, 1'b0, 4'd4, 8'h00, rd, err, waits, c1);
        check("rst_rd4", 32'(rd), 32'h00);
        apb_xfer(2'd0, 1'b0, 4'd6, 8'h00, rd, err, waits, c1);
        check("rst_rd6", 32'(rd), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
